// File: rtl/prog_mem_arbiter.sv
// Arbiter sharing the single-port program RAM between the CPU fetch port and the debug/loader port.
// It uses round-robin grants, a debug bus-lock mode for bursts, and a one-cycle read return.
module prog_mem_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               cpu_gnt,
    output logic               cpu_rvalid,
    output logic [DATA_W-1:0]  cpu_rdata,
    input  logic               dbg_req,
    input  logic               dbg_we,
    input  logic [ADDR_W-1:0]  dbg_addr,
    input  logic [DATA_W-1:0]  dbg_wdata,
    input  logic               dbg_lock,
    output logic               dbg_gnt,
    output logic               dbg_rvalid,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               locked,
    output logic [STALL_W-1:0] cpu_stall_cnt
);

    typedef enum logic {
        ST_RR,
        ST_LOCKED
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    state_t state;
    state_t state_next;
    logic   rr_last;
    logic   rd_valid;
    logic   rd_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RR;
        end else begin
            state <= state_next;
        end
    end

    // Leaving LOCKED takes effect one cycle after dbg_lock falls, so that cycle still arbitrates as locked
    always_comb begin
        state_next = state;
        case (state)
            ST_RR: begin
                if (dbg_gnt && dbg_lock) begin
                    state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!dbg_lock) begin
                    state_next = ST_RR;
                end
            end
            default: state_next = ST_RR;
        endcase
    end

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            case (state)
                ST_LOCKED: begin
                    dbg_gnt = dbg_req;
                end
                default: begin
                    if (cpu_req && dbg_req) begin
                        cpu_gnt = (rr_last == PORT_DBG);
                        dbg_gnt = (rr_last == PORT_CPU);
                    end else begin
                        cpu_gnt = cpu_req;
                        dbg_gnt = dbg_req;
                    end
                end
            endcase
        end
    end

    assign locked    = (state == ST_LOCKED);
    assign mem_en    = cpu_gnt | dbg_gnt;
    assign mem_we    = dbg_gnt & dbg_we;
    assign mem_addr  = cpu_gnt ? cpu_addr : (dbg_gnt ? dbg_addr : '0);
    assign mem_wdata = dbg_gnt ? dbg_wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= PORT_DBG;
        end else if (cpu_gnt) begin
            rr_last <= PORT_CPU;
        end else if (dbg_gnt) begin
            rr_last <= PORT_DBG;
        end
    end

    // Remember who owns the RAM output on the next cycle; writes return nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_owner <= PORT_CPU;
        end else begin
            rd_valid <= cpu_gnt | (dbg_gnt & ~dbg_we);
            rd_owner <= dbg_gnt ? PORT_DBG : PORT_CPU;
        end
    end

    assign cpu_rvalid = rd_valid & (rd_owner == PORT_CPU);
    assign dbg_rvalid = rd_valid & (rd_owner == PORT_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_stall_cnt <= '0;
        end else if (cpu_req && !cpu_gnt && (cpu_stall_cnt != {STALL_W{1'b1}})) begin
            cpu_stall_cnt <= cpu_stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Self-checking bench for prog_mem_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules and an attached RAM.
module tb_prog_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0;
    logic [3:0] cpu_addr = '0;
    logic       cpu_gnt;
    logic       cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       dbg_req = 1'b0;
    logic       dbg_we = 1'b0;
    logic [3:0] dbg_addr = '0;
    logic [7:0] dbg_wdata = '0;
    logic       dbg_lock = 1'b0;
    logic       dbg_gnt;
    logic       dbg_rvalid;
    logic [7:0] dbg_rdata;
    logic       mem_en;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       locked;
    logic [7:0] cpu_stall_cnt;

    logic [7:0] ram [16];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: lock flag, last granted port (0=CPU, 1=DBG), pending read, stall count
    bit         m_locked;
    bit         m_last;
    bit         m_pend_valid;
    bit         m_pend_owner;
    logic [7:0] m_pend_data;
    int         m_stall;
    logic [7:0] ref_mem [16];

    logic       exp_cpu_gnt, exp_dbg_gnt, exp_mem_en, exp_mem_we;
    logic [3:0] exp_mem_addr;
    logic [7:0] exp_mem_wdata;
    logic       exp_cpu_rvalid, exp_dbg_rvalid, exp_locked;
    logic [7:0] exp_cpu_rdata, exp_dbg_rdata, exp_stall;

    always #5 clk = ~clk;

    prog_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .STALL_W(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked), .cpu_stall_cnt(cpu_stall_cnt)
    );

    // Single-port synchronous program RAM
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic model_reset();
        m_locked = 0;
        m_last = 1;
        m_pend_valid = 0;
        m_pend_owner = 0;
        m_pend_data = '0;
        m_stall = 0;
    endtask

    task automatic model_eval();
        exp_cpu_gnt = 0;
        exp_dbg_gnt = 0;
        if (!rst) begin
            if (m_locked) exp_dbg_gnt = dbg_req;
            else if (cpu_req && dbg_req) begin
                exp_cpu_gnt = (m_last == 1);
                exp_dbg_gnt = (m_last == 0);
            end else begin
                exp_cpu_gnt = cpu_req;
                exp_dbg_gnt = dbg_req;
            end
        end
        exp_mem_en     = exp_cpu_gnt || exp_dbg_gnt;
        exp_mem_we     = exp_dbg_gnt && dbg_we;
        exp_mem_addr   = exp_cpu_gnt ? cpu_addr : (exp_dbg_gnt ? dbg_addr : 4'h0);
        exp_mem_wdata  = exp_dbg_gnt ? dbg_wdata : 8'h00;
        exp_cpu_rvalid = m_pend_valid && !m_pend_owner;
        exp_dbg_rvalid = m_pend_valid && m_pend_owner;
        exp_cpu_rdata  = exp_cpu_rvalid ? m_pend_data : 8'h00;
        exp_dbg_rdata  = exp_dbg_rvalid ? m_pend_data : 8'h00;
        exp_locked     = m_locked;
        exp_stall      = 8'(m_stall);
    endtask

    task automatic model_advance();
        m_pend_valid = exp_cpu_gnt || (exp_dbg_gnt && !dbg_we);
        m_pend_owner = exp_dbg_gnt;
        m_pend_data  = exp_cpu_gnt ? ref_mem[cpu_addr] : ref_mem[dbg_addr];
        if (exp_dbg_gnt && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
        if (cpu_req && !exp_cpu_gnt && m_stall < 255) m_stall++;
        if (!m_locked) begin
            if (exp_dbg_gnt && dbg_lock) m_locked = 1;
        end else if (!dbg_lock) begin
            m_locked = 0;
        end
        if (exp_cpu_gnt) m_last = 0;
        else if (exp_dbg_gnt) m_last = 1;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1;
        cpu_req = 0;
        dbg_req = 0;
        dbg_we = 0;
        dbg_lock = 0;
        #1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        cpu_req = 1;
        dbg_req = 1;
        cpu_addr = 4'h7;
        dbg_addr = 4'h9;
        dbg_wdata = 8'h5A;
        #1;
        model_reset();
        n_cmp++;
        if ({cpu_gnt, dbg_gnt, mem_en, mem_we} !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL reset_grants: got %b expected 0000", {cpu_gnt, dbg_gnt, mem_en, mem_we});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== 12'h000) begin
            n_err++;
            $display("[TB] FAIL reset_mem_bus: got %h expected 000", {mem_addr, mem_wdata});
        end
        n_cmp++;
        if ({cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, locked, cpu_stall_cnt} !== 27'h0) begin
            n_err++;
            $display("[TB] FAIL reset_status: got %h expected 0",
                     {cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, locked, cpu_stall_cnt});
        end
        @(posedge clk);
        @(negedge clk);
        cpu_req = 0;
        dbg_req = 0;
        rst = 0;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1;
        cpu_addr = 4'h3;
        dbg_req = 0;
        #1;
        n_cmp++;
        if ({cpu_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 4'h3}) begin
            n_err++;
            $display("[TB] FAIL cpu_read_grant: got %h expected %h", {cpu_gnt, mem_en, mem_we, mem_addr}, {3'b110, 4'h3});
        end
        tick();
        cpu_req = 0;
        #1;
        n_cmp++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h2A}) begin
            n_err++;
            $display("[TB] FAIL cpu_read_data: got %h expected %h", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h2A});
        end
        n_cmp++;
        if ({dbg_gnt, dbg_rvalid, dbg_rdata} !== 10'h0) begin
            n_err++;
            $display("[TB] FAIL cpu_read_dbg_quiet: got %h expected 0", {dbg_gnt, dbg_rvalid, dbg_rdata});
        end
        tick();
    endtask

    task automatic test_alternation();
        logic exp_c;
        apply_reset();
        cpu_req = 1;
        dbg_req = 1;
        dbg_we = 0;
        for (int i = 0; i < 8; i++) begin
            cpu_addr = 4'($urandom);
            dbg_addr = 4'($urandom);
            #1;
            model_eval();
            exp_c = (i % 2 == 0);
            n_cmp++;
            if ({cpu_gnt, dbg_gnt} !== {exp_c, ~exp_c}) begin
                n_err++;
                $display("[TB] FAIL alternate_grant[%0d]: got %b expected %b", i, {cpu_gnt, dbg_gnt}, {exp_c, ~exp_c});
            end
            n_cmp++;
            if (cpu_stall_cnt !== 8'(i / 2)) begin
                n_err++;
                $display("[TB] FAIL alternate_stall[%0d]: got %0d expected %0d", i, cpu_stall_cnt, i / 2);
            end
            n_cmp++;
            if ({cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !==
                {exp_cpu_rvalid, exp_cpu_rdata, exp_dbg_rvalid, exp_dbg_rdata}) begin
                n_err++;
                $display("[TB] FAIL alternate_rdata[%0d]: got %h expected %h", i,
                         {cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata},
                         {exp_cpu_rvalid, exp_cpu_rdata, exp_dbg_rvalid, exp_dbg_rdata});
            end
            tick();
        end
        cpu_req = 0;
        dbg_req = 0;
        tick();
    endtask

    task automatic test_write_then_read();
        dbg_req = 1;
        dbg_we = 1;
        dbg_addr = 4'h5;
        dbg_wdata = 8'h71;
        #1;
        n_cmp++;
        if ({dbg_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 4'h5, 8'h71}) begin
            n_err++;
            $display("[TB] FAIL write_bus: got %h expected %h", {dbg_gnt, mem_we, mem_addr, mem_wdata}, {2'b11, 4'h5, 8'h71});
        end
        tick();
        dbg_req = 0;
        dbg_we = 0;
        cpu_req = 1;
        cpu_addr = 4'h5;
        #1;
        n_cmp++;
        if ({dbg_rvalid, cpu_gnt} !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL write_no_rvalid: got %b expected 01", {dbg_rvalid, cpu_gnt});
        end
        tick();
        cpu_req = 0;
        #1;
        n_cmp++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h71}) begin
            n_err++;
            $display("[TB] FAIL write_readback: got %h expected %h", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h71});
        end
        tick();
    endtask

    task automatic test_lock_burst();
        int waited;
        cpu_req = 1;
        cpu_addr = 4'h2;
        tick();
        for (int k = 0; k < 4; k++) begin
            dbg_req = 1;
            dbg_we = 1;
            dbg_lock = 1;
            dbg_addr = 4'(8 + k);
            dbg_wdata = 8'($urandom);
            #1;
            n_cmp++;
            if ({cpu_gnt, dbg_gnt, locked} !== {2'b01, (k > 0)}) begin
                n_err++;
                $display("[TB] FAIL lock_burst[%0d]: got %b expected %b", k, {cpu_gnt, dbg_gnt, locked}, {2'b01, (k > 0)});
            end
            tick();
        end
        dbg_req = 0;
        dbg_we = 0;
        dbg_lock = 0;
        waited = 0;
        #1;
        while (cpu_gnt !== 1'b1 && waited < 4) begin
            tick();
            waited++;
            #1;
        end
        n_cmp++;
        if (waited != 1) begin
            n_err++;
            $display("[TB] FAIL unlock_latency: got %0d cycles expected 1", waited);
        end
        tick();
        cpu_req = 0;
        tick();
    endtask

    task automatic test_stall_saturate();
        apply_reset();
        dbg_req = 1;
        dbg_we = 0;
        dbg_lock = 1;
        tick();
        dbg_req = 0;
        cpu_req = 1;
        for (int j = 0; j < 300; j++) begin
            if (j == 100) begin
                #1;
                n_cmp++;
                if ({locked, cpu_stall_cnt} !== {1'b1, 8'd100}) begin
                    n_err++;
                    $display("[TB] FAIL stall_mid: got %h expected %h", {locked, cpu_stall_cnt}, {1'b1, 8'd100});
                end
            end
            tick();
        end
        #1;
        n_cmp++;
        if ({cpu_gnt, cpu_stall_cnt} !== {1'b0, 8'd255}) begin
            n_err++;
            $display("[TB] FAIL stall_saturate: got %h expected %h", {cpu_gnt, cpu_stall_cnt}, {1'b0, 8'd255});
        end
        dbg_lock = 0;
        tick();
        tick();
        cpu_req = 0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        cpu_req = 1;
        cpu_addr = 4'h3;
        dbg_req = 0;
        model_eval();
        @(posedge clk);
        model_advance();
        #1;
        cpu_req = 0;
        rst = 1;
        #1;
        model_reset();
        n_cmp++;
        if ({cpu_rvalid, cpu_rdata, locked, cpu_stall_cnt} !== 18'h0) begin
            n_err++;
            $display("[TB] FAIL mid_read_reset: got %h expected 0", {cpu_rvalid, cpu_rdata, locked, cpu_stall_cnt});
        end
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        cpu_req = 1;
        dbg_req = 1;
        dbg_we = 0;
        #1;
        n_cmp++;
        if ({cpu_gnt, dbg_gnt, cpu_rvalid} !== 3'b100) begin
            n_err++;
            $display("[TB] FAIL reset_first_tie: got %b expected 100", {cpu_gnt, dbg_gnt, cpu_rvalid});
        end
        tick();
        cpu_req = 0;
        dbg_req = 0;
        tick();
    endtask

    task automatic test_random();
        bit cpu_hold = 0;
        bit dbg_hold = 0;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if (!cpu_hold) begin
                cpu_req = 1'($urandom_range(0, 1));
                cpu_addr = 4'($urandom);
            end
            if (!dbg_hold) begin
                dbg_req = 1'($urandom_range(0, 1));
                dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 4'($urandom);
                dbg_wdata = 8'($urandom);
            end
            dbg_lock = ($urandom_range(0, 2) == 0);
            #1;
            model_eval();
            n_cmp++;
            if ({cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
                {exp_cpu_gnt, exp_dbg_gnt, exp_mem_en, exp_mem_we, exp_mem_addr, exp_mem_wdata}) begin
                n_err++;
                $display("[TB] FAIL rand_bus[%0d]: got %h expected %h", i,
                         {cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata},
                         {exp_cpu_gnt, exp_dbg_gnt, exp_mem_en, exp_mem_we, exp_mem_addr, exp_mem_wdata});
            end
            n_cmp++;
            if ({cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata} !==
                {exp_cpu_rvalid, exp_cpu_rdata, exp_dbg_rvalid, exp_dbg_rdata}) begin
                n_err++;
                $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", i,
                         {cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata},
                         {exp_cpu_rvalid, exp_cpu_rdata, exp_dbg_rvalid, exp_dbg_rdata});
            end
            n_cmp++;
            if ({locked, cpu_stall_cnt} !== {exp_locked, exp_stall}) begin
                n_err++;
                $display("[TB] FAIL rand_status[%0d]: got %h expected %h", i,
                         {locked, cpu_stall_cnt}, {exp_locked, exp_stall});
            end
            cpu_hold = cpu_req && !exp_cpu_gnt;
            dbg_hold = dbg_req && !exp_dbg_gnt;
            tick();
        end
        cpu_req = 0;
        dbg_req = 0;
        dbg_lock = 0;
        tick();
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin
            ram[a] = 8'($urandom);
        end
        ram[3] = 8'h2A;
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = ram[a];
        end
        model_reset();
        @(negedge clk);
        test_reset();
        test_cpu_read();
        test_alternation();
        test_write_then_read();
        test_lock_burst();
        test_stall_saturate();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
